// File: rtl/sifive_dcache_tl_d_arbiter.sv
// sifive_dcache_tl_d_arbiter
// Merges N TileLink D-channel response sources onto the single hart-0 dcache
// D channel. A data-carrying multi-beat response locks the grant to its source
// until the last beat is accepted.
// Build option: define SIFIVE_DCACHE_TL_D_ARB_RR_EN for round-robin
// arbitration; otherwise fixed priority (lowest index wins).
module sifive_dcache_tl_d_arbiter #(
    parameter int N        = 2,
    parameter int MAX_SIZE = 6
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [3*N-1:0]  in_opcode,
    input  logic [2*N-1:0]  in_param,
    input  logic [4*N-1:0]  in_size,
    input  logic [3*N-1:0]  in_source,
    input  logic [N-1:0]    in_sink,
    input  logic [N-1:0]    in_denied,
    input  logic [N-1:0]    in_corrupt,
    input  logic [32*N-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_opcode,
    output logic [1:0]      out_param,
    output logic [3:0]      out_size,
    output logic [2:0]      out_source,
    output logic            out_sink,
    output logic            out_denied,
    output logic            out_corrupt,
    output logic [31:0]     out_data,
    output logic [N-1:0]    grant,
    output logic            locked,
    output logic            size_err
);

    localparam int IDXW = $clog2(N);
    // Wide enough to hold the full beat count of the largest burst.
    localparam int BLW = MAX_SIZE - 1;
    localparam logic [3:0] MAX_SIZE_L = 4'(MAX_SIZE);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [BLW-1:0]  beats_left_reg, beats_left_next;
    logic [IDXW-1:0] lock_idx_reg, lock_idx_next;
    logic [IDXW-1:0] hold_idx_reg, hold_idx_next;
    logic            hold_vld_reg, hold_vld_next;
    logic            size_err_reg, size_err_next;

    logic [IDXW-1:0] win_idx;
    logic            any_valid;
    logic [IDXW-1:0] cur_idx;
    logic            cur_sel;
    logic [N-1:0]    sel_valid;
    logic            beat;
    logic            is_data;
    logic            size_over;
    logic [3:0]      size_eff;
    logic [BLW-1:0]  beat_count;

`ifdef SIFIVE_DCACHE_TL_D_ARB_RR_EN
    logic [IDXW-1:0] rr_ptr_reg, rr_ptr_next;

    // Round-robin pick: the valid source nearest after the pointer wins.
    always_comb begin
        int best_dist;
        int dist;
        win_idx   = '0;
        any_valid = 1'b0;
        best_dist = N;
        dist      = 0;
        for (int i = 0; i < N; i++) begin
            dist = (i + 2 * N - 1 - int'(rr_ptr_reg)) % N;
            if (in_valid[i] && (dist < best_dist)) begin
                best_dist = dist;
                win_idx   = IDXW'(i);
                any_valid = 1'b1;
            end
        end
    end

    // Pointer moves to the winner of every accepted first beat.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if ((state_reg == IDLE) && beat) begin
            rr_ptr_next = cur_idx;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end
`else
    // Fixed priority pick: lowest valid index wins.
    always_comb begin
        win_idx   = '0;
        any_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                win_idx   = IDXW'(i);
                any_valid = 1'b1;
            end
        end
    end
`endif

    // Current selection: burst owner, else a held stalled winner, else a fresh pick.
    // Only registered state and in_valid feed this, never out_ready.
    always_comb begin
        cur_idx = win_idx;
        cur_sel = any_valid;
        if (state_reg == BURST) begin
            cur_idx = lock_idx_reg;
            cur_sel = 1'b1;
        end else if (hold_vld_reg) begin
            cur_idx = hold_idx_reg;
            cur_sel = 1'b1;
        end
        if (!reset_n) begin
            cur_sel = 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_port
            assign grant[gi]     = cur_sel && (cur_idx == IDXW'(gi));
            assign in_ready[gi]  = out_ready & grant[gi];
            assign sel_valid[gi] = in_valid[gi] & grant[gi];
        end
    endgenerate

    assign out_valid = |sel_valid;
    assign beat      = out_valid & out_ready;
    assign locked    = (state_reg == BURST);
    assign size_err  = size_err_reg;

    // AND-OR field mux; all fields read zero when nothing is granted.
    always_comb begin
        out_opcode  = '0;
        out_param   = '0;
        out_size    = '0;
        out_source  = '0;
        out_sink    = 1'b0;
        out_denied  = 1'b0;
        out_corrupt = 1'b0;
        out_data    = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                out_opcode  = in_opcode[i*3 +: 3];
                out_param   = in_param[i*2 +: 2];
                out_size    = in_size[i*4 +: 4];
                out_source  = in_source[i*3 +: 3];
                out_sink    = in_sink[i];
                out_denied  = in_denied[i];
                out_corrupt = in_corrupt[i];
                out_data    = in_data[i*32 +: 32];
            end
        end
    end

    // Beat count of the presented response; oversize requests count as MAX_SIZE.
    always_comb begin
        is_data    = (out_opcode == 3'd1) || (out_opcode == 3'd5);
        size_over  = (out_size > MAX_SIZE_L);
        size_eff   = size_over ? MAX_SIZE_L : out_size;
        beat_count = BLW'(1);
        if (is_data && (size_eff > 4'd2)) begin
            beat_count = BLW'(1) << (size_eff - 4'd2);
        end
    end

    // Lock FSM, stall-hold and sticky size error next-state logic.
    always_comb begin
        state_next      = state_reg;
        beats_left_next = beats_left_reg;
        lock_idx_next   = lock_idx_reg;
        hold_vld_next   = hold_vld_reg;
        hold_idx_next   = hold_idx_reg;
        size_err_next   = size_err_reg;
        case (state_reg)
            IDLE: begin
                if (beat) begin
                    hold_vld_next = 1'b0;
                    if (size_over) begin
                        size_err_next = 1'b1;
                    end
                    if (beat_count > BLW'(1)) begin
                        state_next      = BURST;
                        beats_left_next = beat_count - BLW'(1);
                        lock_idx_next   = cur_idx;
                    end
                end else if (out_valid) begin
                    // Stalled by the dcache: freeze this winner until its beat.
                    hold_vld_next = 1'b1;
                    hold_idx_next = cur_idx;
                end
            end
            BURST: begin
                if (beat) begin
                    beats_left_next = beats_left_reg - BLW'(1);
                    if (beats_left_reg == BLW'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            beats_left_reg <= '0;
            lock_idx_reg   <= '0;
            hold_idx_reg   <= '0;
            hold_vld_reg   <= 1'b0;
            size_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            beats_left_reg <= beats_left_next;
            lock_idx_reg   <= lock_idx_next;
            hold_idx_reg   <= hold_idx_next;
            hold_vld_reg   <= hold_vld_next;
            size_err_reg   <= size_err_next;
        end
    end

endmodule

// File: tb/tb_sifive_dcache_tl_d_arbiter.sv
// Scoreboard bench for sifive_dcache_tl_d_arbiter (N=2, MAX_SIZE=6).
// Per-source sender processes play TileLink D sources; a monitor checks every
// accepted beat, stall cycle and burst bubble against the expected queue.
module tb_sifive_dcache_tl_d_arbiter;

    typedef struct packed {
        logic [2:0]  op;
        logic [1:0]  param;
        logic [3:0]  size;
        logic [2:0]  src;
        logic        sink;
        logic        denied;
        logic        corrupt;
        logic [31:0] data;
    } beat_t;

    typedef struct packed {
        logic [1:0] grant;
        logic       locked;
        beat_t      f;
    } exp_t;

    typedef struct {
        int    gap;
        beat_t f;
    } item_t;

    logic        clk;
    logic        reset_n;
    logic [1:0]  in_valid, in_ready;
    logic [5:0]  in_opcode;
    logic [3:0]  in_param;
    logic [7:0]  in_size;
    logic [5:0]  in_source;
    logic [1:0]  in_sink, in_denied, in_corrupt;
    logic [63:0] in_data;
    logic        out_valid, out_ready;
    logic [2:0]  out_opcode;
    logic [1:0]  out_param;
    logic [3:0]  out_size;
    logic [2:0]  out_source;
    logic        out_sink, out_denied, out_corrupt;
    logic [31:0] out_data;
    logic [1:0]  grant;
    logic        locked, size_err;

    logic  src_valid [2];
    beat_t src_f [2];
    item_t src_q [2][$];
    exp_t  sb [$];
    logic  flush;
    logic  tgl;
    int    vectors;
    int    fails;

    sifive_dcache_tl_d_arbiter #(.N(2), .MAX_SIZE(6)) dut (
        .clock      (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_param   (in_param),
        .in_size    (in_size),
        .in_source  (in_source),
        .in_sink    (in_sink),
        .in_denied  (in_denied),
        .in_corrupt (in_corrupt),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_param  (out_param),
        .out_size   (out_size),
        .out_source (out_source),
        .out_sink   (out_sink),
        .out_denied (out_denied),
        .out_corrupt(out_corrupt),
        .out_data   (out_data),
        .grant      (grant),
        .locked     (locked),
        .size_err   (size_err)
    );

    assign in_valid   = {src_valid[1], src_valid[0]};
    assign in_opcode  = {src_f[1].op, src_f[0].op};
    assign in_param   = {src_f[1].param, src_f[0].param};
    assign in_size    = {src_f[1].size, src_f[0].size};
    assign in_source  = {src_f[1].src, src_f[0].src};
    assign in_sink    = {src_f[1].sink, src_f[0].sink};
    assign in_denied  = {src_f[1].denied, src_f[0].denied};
    assign in_corrupt = {src_f[1].corrupt, src_f[0].corrupt};
    assign in_data    = {src_f[1].data, src_f[0].data};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic beat_t mk(input logic [2:0] op, input logic [3:0] sz, input logic [31:0] d);
        beat_t b;
        b.op      = op;
        b.param   = d[1:0];
        b.size    = sz;
        b.src     = d[4:2];
        b.sink    = d[5];
        b.denied  = d[6];
        b.corrupt = d[7];
        b.data    = d;
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        vectors++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end else begin
            $display("ok   %s = %h", name, got);
        end
    endtask

    task automatic send(input int s, input beat_t f, input int gap);
        item_t it;
        it.gap = gap;
        it.f   = f;
        src_q[s].push_back(it);
    endtask

    task automatic exp_beat(input int s, input beat_t f, input logic lk);
        exp_t e;
        e.grant  = (s == 0) ? 2'b01 : 2'b10;
        e.locked = lk;
        e.f      = f;
        sb.push_back(e);
    endtask

    task automatic send_burst(input int s, input logic [2:0] op, input logic [3:0] sz, input int n,
                              input logic [31:0] base, input int first_gap, input int bub_idx, input int bub_len);
        for (int k = 0; k < n; k++) begin
            send(s, mk(op, sz, base + 32'(k)), (k == 0) ? first_gap : ((k == bub_idx) ? bub_len : 0));
        end
    endtask

    task automatic exp_burst(input int s, input logic [2:0] op, input logic [3:0] sz, input int n,
                             input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            exp_beat(s, mk(op, sz, base + 32'(k)), (k != 0));
        end
    endtask

    // One TileLink source: presents queued beats in order and never retracts valid.
    task automatic run_source(input int s);
        int    waited;
        bit    presenting;
        bit    acc;
        item_t it;
        waited     = 0;
        presenting = 0;
        forever begin
            @(negedge clk);
            acc = presenting && in_ready[s];
            @(posedge clk);
            #1;
            if (flush) begin
                presenting   = 0;
                waited       = 0;
                src_valid[s] = 1'b0;
            end else begin
                if (acc) begin
                    presenting   = 0;
                    src_valid[s] = 1'b0;
                end
                if (!presenting && src_q[s].size() > 0) begin
                    if (waited < src_q[s][0].gap) begin
                        waited++;
                    end else begin
                        it           = src_q[s].pop_front();
                        src_f[s]     = it.f;
                        src_valid[s] = 1'b1;
                        presenting   = 1;
                        waited       = 0;
                    end
                end
            end
        end
    endtask

    initial run_source(0);
    initial run_source(1);

    // dcache side ready: held high, or toggling every cycle when tgl is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = tgl ? ~out_ready : 1'b1;
        end
    end

    // Monitor: compare every beat, stall and burst bubble against the scoreboard.
    initial begin
        exp_t g;
        exp_t e;
        logic [1:0] last_grant;
        last_grant = 2'b00;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                g.grant  = grant;
                g.locked = locked;
                g.f      = {out_opcode, out_param, out_size, out_source,
                            out_sink, out_denied, out_corrupt, out_data};
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        fails++;
                        $display("FAIL unexpected_beat got=%h required=none", g);
                    end else begin
                        e = sb.pop_front();
                        chk("beat", 64'(g), 64'(e));
                        last_grant = e.grant;
                    end
                end else if (out_valid && sb.size() > 0) begin
                    chk("stall", 64'(g), 64'(sb[0]));
                end else if (!out_valid && locked) begin
                    chk("bubble_grant", 64'(grant), 64'(last_grant));
                end
            end
        end
    end

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            #1;
            cyc++;
        end while ((sb.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0) && cyc < 400);
        if (sb.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0) begin
            vectors++;
            fails++;
            $display("FAIL %s drain_timeout pending=%0d required=0", name, sb.size());
            sb.delete();
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors      = 0;
        fails        = 0;
        reset_n      = 1'b0;
        out_ready    = 1'b1;
        tgl          = 1'b0;
        flush        = 1'b0;
        src_valid[0] = 1'b0;
        src_valid[1] = 1'b0;
        src_f[0]     = '0;
        src_f[1]     = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_locked", 64'(locked), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_size_err", 64'(size_err), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Single-beat contention: AccessAck sizes 2..5 on source 0,
        // AccessAckData size 2 on source 1, all one beat each.
        for (int k = 0; k < 4; k++) begin
            send(0, mk(3'd0, 4'(2 + k), 32'h1000_0000 + 32'(k)), 0);
            send(1, mk(3'd1, 4'd2, 32'h1100_00A0 + 32'(k)), 0);
        end
`ifdef SIFIVE_DCACHE_TL_D_ARB_RR_EN
        for (int k = 0; k < 4; k++) begin
            exp_beat(1, mk(3'd1, 4'd2, 32'h1100_00A0 + 32'(k)), 1'b0);
            exp_beat(0, mk(3'd0, 4'(2 + k), 32'h1000_0000 + 32'(k)), 1'b0);
        end
`else
        for (int k = 0; k < 4; k++) exp_beat(0, mk(3'd0, 4'(2 + k), 32'h1000_0000 + 32'(k)), 1'b0);
        for (int k = 0; k < 4; k++) exp_beat(1, mk(3'd1, 4'd2, 32'h1100_00A0 + 32'(k)), 1'b0);
`endif
        drain("single_beat");

        // Burst lock: source 0 AccessAckData size 4, source 1 valid from the next cycle.
        send_burst(0, 3'd1, 4'd4, 4, 32'h2000_0040, 0, -1, 0);
        send(1, mk(3'd0, 4'd2, 32'h2100_0013), 1);
        exp_burst(0, 3'd1, 4'd4, 4, 32'h2000_0040);
        exp_beat(1, mk(3'd0, 4'd2, 32'h2100_0013), 1'b0);
        drain("burst_lock");

        // Backpressure: toggling ready over a 4-beat burst and contended singles.
        tgl = 1'b1;
        send_burst(0, 3'd1, 4'd4, 4, 32'h3000_00E0, 0, -1, 0);
        send(0, mk(3'd0, 4'd2, 32'h3000_0A55), 0);
        send(1, mk(3'd0, 4'd1, 32'h3100_0B2A), 0);
        send(1, mk(3'd0, 4'd2, 32'h3100_0C7F), 0);
        exp_burst(0, 3'd1, 4'd4, 4, 32'h3000_00E0);
`ifdef SIFIVE_DCACHE_TL_D_ARB_RR_EN
        exp_beat(1, mk(3'd0, 4'd1, 32'h3100_0B2A), 1'b0);
        exp_beat(0, mk(3'd0, 4'd2, 32'h3000_0A55), 1'b0);
        exp_beat(1, mk(3'd0, 4'd2, 32'h3100_0C7F), 1'b0);
`else
        exp_beat(0, mk(3'd0, 4'd2, 32'h3000_0A55), 1'b0);
        exp_beat(1, mk(3'd0, 4'd1, 32'h3100_0B2A), 1'b0);
        exp_beat(1, mk(3'd0, 4'd2, 32'h3100_0C7F), 1'b0);
`endif
        drain("backpressure");
        tgl = 1'b0;

        // Valid bubble: source 1 GrantData size 6 (16 beats), 3 idle cycles before beat index 5.
        send_burst(1, 3'd5, 4'd6, 16, 32'h4100_0060, 0, 5, 3);
        send(0, mk(3'd0, 4'd2, 32'h4000_0099), 2);
        exp_burst(1, 3'd5, 4'd6, 16, 32'h4100_0060);
        exp_beat(0, mk(3'd0, 4'd2, 32'h4000_0099), 1'b0);
        drain("valid_bubble");

        // Size error: AccessAckData size 7 clamps to 16 beats and sets the sticky flag.
        chk("size_err_before", 64'(size_err), 64'(0));
        send_burst(0, 3'd1, 4'd7, 16, 32'h5000_00C0, 0, -1, 0);
        exp_burst(0, 3'd1, 4'd7, 16, 32'h5000_00C0);
        drain("size_err_burst");
        chk("size_err_set", 64'(size_err), 64'(1));

        // Reset mid-burst: accept 2 of 4 beats, then reset.
        send_burst(0, 3'd1, 4'd4, 4, 32'h6000_0020, 0, -1, 0);
        send(1, mk(3'd0, 4'd2, 32'h6100_0011), 1);
        exp_burst(0, 3'd1, 4'd4, 2, 32'h6000_0020);
        begin
            int cyc;
            cyc = 0;
            do begin
                @(negedge clk);
                #1;
                cyc++;
            end while (sb.size() != 0 && cyc < 100);
            if (sb.size() != 0) begin
                vectors++;
                fails++;
                $display("FAIL reset_mid_burst beats_seen timeout pending=%0d required=0", sb.size());
                sb.delete();
            end
        end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        flush   = 1'b1;
        src_q[0].delete();
        src_q[1].delete();
        @(negedge clk);
        chk("rst_low_grant", 64'(grant), 64'(0));
        chk("rst_low_out_valid", 64'(out_valid), 64'(0));
        chk("size_err_sticky", 64'(size_err), 64'(1));
        @(negedge clk);
        chk("post_rst_locked", 64'(locked), 64'(0));
        chk("post_rst_grant", 64'(grant), 64'(0));
        chk("post_rst_size_err", 64'(size_err), 64'(0));
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        flush   = 1'b0;

        // Fresh arbitration after reset (pointer back at 0).
        send(0, mk(3'd0, 4'd2, 32'h7000_0033), 0);
        send(1, mk(3'd0, 4'd2, 32'h7100_0044), 0);
`ifdef SIFIVE_DCACHE_TL_D_ARB_RR_EN
        exp_beat(1, mk(3'd0, 4'd2, 32'h7100_0044), 1'b0);
        exp_beat(0, mk(3'd0, 4'd2, 32'h7000_0033), 1'b0);
`else
        exp_beat(0, mk(3'd0, 4'd2, 32'h7000_0033), 1'b0);
        exp_beat(1, mk(3'd0, 4'd2, 32'h7100_0044), 1'b0);
`endif
        drain("post_reset_arb");
        chk("final_locked", 64'(locked), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
